// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types for the multiplier issue controller:
// opcode and state encodings plus operand/half-select helpers.
package mul_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } mul_state_e;

  localparam logic [1:0] TOK_NONE   = 2'b00;
  localparam logic [1:0] TOK_LAUNCH = 2'b01;

  function automatic logic sel_high(input mul_op_e op);
    return op != OP_MUL;
  endfunction

  function automatic logic rs1_signed(input mul_op_e op);
    return op != OP_MULHU;
  endfunction

  function automatic logic rs2_signed(input mul_op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry product cache keyed on operands and opcode.
// MUL hits any entry: the low half ignores signedness.
module mul_result_cache
  import mul_issue_ctrl_pkg::*;
#(
  parameter int DataWidth = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  mul_op_e                wr_op_i,
  input  logic [DataWidth-1:0]   wr_rs1_i,
  input  logic [DataWidth-1:0]   wr_rs2_i,
  input  logic [2*DataWidth-1:0] wr_prod_i,
  input  mul_op_e                lk_op_i,
  input  logic [DataWidth-1:0]   lk_rs1_i,
  input  logic [DataWidth-1:0]   lk_rs2_i,
  output logic                   hit_o,
  output logic [2*DataWidth-1:0] prod_o
);

  logic                   valid_q;
  mul_op_e                op_q;
  logic [DataWidth-1:0]   rs1_q;
  logic [DataWidth-1:0]   rs2_q;
  logic [2*DataWidth-1:0] prod_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      op_q    <= OP_MUL;
      rs1_q   <= '0;
      rs2_q   <= '0;
      prod_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      op_q    <= wr_op_i;
      rs1_q   <= wr_rs1_i;
      rs2_q   <= wr_rs2_i;
      prod_q  <= wr_prod_i;
    end
  end

  assign hit_o = valid_q
              && (lk_rs1_i == rs1_q)
              && (lk_rs2_i == rs2_q)
              && ((lk_op_i == OP_MUL) || (lk_op_i == op_q));

  assign prod_o = prod_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller for the pipelined multiplier:
// operand extension, launch token, watchdog, flush and result cache.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int DataWidth     = 64,
  parameter int MulLatency    = 5,
  parameter int WatchdogSlack = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic [1:0]             req_op_i,
  input  logic [DataWidth-1:0]   req_rs1_i,
  input  logic [DataWidth-1:0]   req_rs2_i,
  input  logic [4:0]             req_rd_i,
  input  logic                   flush_i,
  output logic                   mul_hold_to_ex_o,
  output logic [DataWidth:0]     mul_multiplicand_o,
  output logic [DataWidth:0]     mul_multiplier_o,
  output logic [1:0]             mul_hold_flag_to_dp_o,
  input  logic                   mul_hold_end_from_dp_i,
  input  logic [2*DataWidth-1:0] mul_product_i,
  output logic                   resp_valid_o,
  output logic [DataWidth-1:0]   resp_data_o,
  output logic [4:0]             resp_rd_o,
  output logic                   mul_error_o
);

  localparam int WdLim = MulLatency + WatchdogSlack;
  localparam int WdW   = $clog2(WdLim + 1);
  localparam logic [WdW-1:0] WdLoad = WdW'(WdLim);

  mul_state_e           state_q;
  mul_op_e              op_q;
  logic [4:0]           rd_q;
  logic [DataWidth-1:0] rs1_q;
  logic [DataWidth-1:0] rs2_q;
  logic [WdW-1:0]       wdog_q;
  logic [WdW-1:0]       wdog_d;
  logic [DataWidth:0]   mcand_q;
  logic [DataWidth:0]   mplier_q;
  logic [1:0]           tok_q;
  logic                 resp_valid_q;
  logic [DataWidth-1:0] resp_data_q;
  logic [4:0]           resp_rd_q;
  logic                 err_q;

  mul_op_e                req_op;
  logic                   accept;
  logic                   end_tok;
  logic                   expire;
  logic                   in_flight;
  logic                   cache_hit;
  logic                   cache_wr;
  logic                   cache_clr;
  logic [2*DataWidth-1:0] cache_prod;
  logic [DataWidth:0]     ext_a;
  logic [DataWidth:0]     ext_b;

  function automatic logic [DataWidth-1:0] pick(
    input mul_op_e                op,
    input logic [2*DataWidth-1:0] p
  );
    return sel_high(op) ? p[2*DataWidth-1:DataWidth]
                        : p[DataWidth-1:0];
  endfunction

  assign req_op    = mul_op_e'(req_op_i);
  assign end_tok   = mul_hold_end_from_dp_i;
  assign accept    = (state_q == S_IDLE) && req_valid_i && !flush_i;
  assign in_flight = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign wdog_d    = (wdog_q == '0) ? '0 : wdog_q - WdW'(1);
  assign expire    = (wdog_d == '0);

  assign ext_a = {rs1_signed(req_op) & req_rs1_i[DataWidth-1], req_rs1_i};
  assign ext_b = {rs2_signed(req_op) & req_rs2_i[DataWidth-1], req_rs2_i};

  // A flush or a lost token invalidates the entry so a replay relaunches.
  assign cache_wr  = (state_q == S_WAIT) && end_tok && !flush_i;
  assign cache_clr = (in_flight && flush_i)
                  || ((state_q == S_WAIT) && !end_tok && expire);

  mul_result_cache #(
    .DataWidth (DataWidth)
  ) u_cache (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cache_clr),
    .wr_i      (cache_wr),
    .wr_op_i   (op_q),
    .wr_rs1_i  (rs1_q),
    .wr_rs2_i  (rs2_q),
    .wr_prod_i (mul_product_i),
    .lk_op_i   (req_op),
    .lk_rs1_i  (req_rs1_i),
    .lk_rs2_i  (req_rs2_i),
    .hit_o     (cache_hit),
    .prod_o    (cache_prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      op_q         <= OP_MUL;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      wdog_q       <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      tok_q        <= TOK_NONE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      tok_q        <= TOK_NONE;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          err_q <= end_tok;
          if (accept) begin
            op_q  <= req_op;
            rd_q  <= req_rd_i;
            rs1_q <= req_rs1_i;
            rs2_q <= req_rs2_i;
            if (cache_hit) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= pick(req_op, cache_prod);
              resp_rd_q    <= req_rd_i;
            end else begin
              state_q  <= S_LAUNCH;
              mcand_q  <= ext_a;
              mplier_q <= ext_b;
              tok_q    <= TOK_LAUNCH;
              wdog_q   <= WdLoad;
            end
          end
        end
        S_LAUNCH: begin
          wdog_q  <= wdog_d;
          state_q <= flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_d;
          if (flush_i) begin
            state_q <= end_tok ? S_IDLE : S_DRAIN;
          end else if (end_tok) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= pick(op_q, mul_product_i);
            resp_rd_q    <= rd_q;
          end else if (expire) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end
        end
        S_RESP: begin
          err_q   <= end_tok;
          state_q <= S_IDLE;
        end
        S_DRAIN: begin
          wdog_q <= wdog_d;
          if (end_tok || expire) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_hold_to_ex_o      = accept || in_flight;
  assign mul_multiplicand_o    = mcand_q;
  assign mul_multiplier_o      = mplier_q;
  assign mul_hold_flag_to_dp_o = tok_q;
  assign resp_valid_o          = resp_valid_q;
  assign resp_data_o           = resp_data_q;
  assign resp_rd_o             = resp_rd_q;
  assign mul_error_o           = err_q;

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Sequencing controller for the pipelined Wallace-tree multiplier. It accepts one multiply request at a time from the Ex stage and prepares sign/zero-extended operands per RV64M opcode. It launches the operation into the partial-product pipeline with a hold-flag token and holds Ex until the end token returns. It then selects the low or high product half and returns the result. It also handles pipeline flushes, a watchdog on lost tokens, and a one-entry product cache so that a MULH/MUL pair on identical operands costs one pipeline pass.

## Interface
- DataWidth, 64, operand width
- MulLatency, 5, cycles from launch token to end token in the datapath
- WatchdogSlack, 2, extra cycles tolerated beyond MulLatency before error

- Clk  in  1  clock, all logic on posedge
- Rst  in  1  reset, synchronous, active-high
- ReqValid  in  1  multiply request from Ex
- ReqOp  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- ReqRs1, ReqRs2  in  DataWidth  operands
- ReqRd  in  5  destination register tag
- Flush  in  1  pipeline kill from control
- MulHoldToEx  out  1  stall Ex
- MulMultiplicand, MulMultiplier  out  DataWidth+1  extended operands to datapath
- MulHoldFlagToDp  out  2  launch token; 2'b01 for one cycle on launch, else 2'b00
- MulHoldEndFromDp  in  1  end token from final adder stage
- MulProduct  in  2*DataWidth  datapath product, valid with MulHoldEndFromDp
- RespValid  out  1  one-cycle result strobe
- RespData  out  DataWidth  selected result
- RespRd  out  5  tag of returned result
- MulError  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, LAUNCH, WAIT, RESP, DRAIN.
- IDLE: request accepted when ReqValid && !Flush. Flush wins over simultaneous ReqValid, and the request is dropped. Op, Rd, Rs1, Rs2 are latched on accept.
- Cache hit on accept: CacheValid, Rs1/Rs2 equal to cached values, and either ReqOp==MUL or ReqOp equals the cached op. On hit, go to RESP directly without launching.
- Cache miss: go to LAUNCH.
- LAUNCH (1 cycle): drive extended operands, MulHoldFlagToDp=2'b01, load watchdog = MulLatency+WatchdogSlack, then go to WAIT.
- Operand extension: MULH sign/sign; MULHSU sign/zero; MULHU zero/zero; MUL sign/sign.
- WAIT: decrement watchdog each cycle. On MulHoldEndFromDp, capture MulProduct, update cache (product, Rs1, Rs2, op; CacheValid=1), then go to RESP. If the watchdog reaches 0 first: pulse MulError, clear CacheValid, go to IDLE.
- RESP (1 cycle): RespValid=1. RespData = MUL ? Product[DataWidth-1:0] : Product[2*DataWidth-1:DataWidth]. RespRd = latched Rd. Then go to IDLE.
- Flush in LAUNCH or WAIT: go to DRAIN. MulHoldToEx drops next cycle, no RespValid, CacheValid cleared. A flush during LAUNCH still emits that cycle's token.
- DRAIN: no accepts. Go to IDLE on MulHoldEndFromDp (product discarded, cache not written) or on watchdog expiry (no MulError).
- Flush in RESP: RespValid still asserted (the consumer discards it). The cache keeps its entry.
- MulHoldEndFromDp in IDLE or RESP is spurious: ignore it and pulse MulError.

## Timing
- Reset values: state IDLE, all outputs 0, CacheValid 0, watchdog 0.
- MulHoldToEx = (IDLE && ReqValid && !Flush) || LAUNCH || WAIT. It is combinational and deasserts in the RESP cycle.
- Miss latency: accept at T, launch at T+1, end token at T+1+MulLatency, RespValid at T+2+MulLatency (T+7 by default).
- Hit latency: accept at T, RespValid at T+1.
- Next accept is possible in the cycle after RESP, which gives one op per MulLatency+3 cycles on misses.
- All outputs except MulHoldToEx are registered.

## Structure
- Shared package: ReqOp encodings, state encoding, and the MUL/high-half select helper.
- One natural sub-module: mul_result_cache, holding the one-entry product/operand/op store plus the hit compare.
- Extension logic and the FSM stay in the top module.

## Test plan
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 -> RespData 0x1 at T+7; MulHoldToEx high T..T+6; MulHoldFlagToDp 2'b01 at T+1 only.
- MULH 0xFFFF_FFFF_FFFF_FFFF (−1) × 2, then MUL with the same operands in the cycle after RESP -> first RespData 0xFFFF_FFFF_FFFF_FFFF at T+7; second RespData 0xFFFF_FFFF_FFFF_FFFE at one cycle after its accept, with no new launch token.
- MULHSU −1 × 2 -> RespData 0xFFFF_FFFF_FFFF_FFFF. Then MULHU with the same operands -> cache miss and relaunch, RespData 0x1.
- Flush at T+3 of a MUL -> MulHoldToEx low from T+4, no RespValid. A ReqValid held high is not accepted until the cycle after the end token. A subsequent identical request misses.
- End token withheld -> MulError pulse at T+1+MulLatency+WatchdogSlack (T+8), state IDLE, CacheValid 0.
- Rst asserted during WAIT -> next cycle all outputs 0 and state IDLE; a late end token then raises MulError.
